// File: rtl/apb4_master_bridge.sv
// apb4_master_bridge: APB4 initiator that turns a valid/ready command into one
// APB4 SETUP/ACCESS transfer and returns the result on a valid/ready response.
// One transfer in flight at a time; optional ACCESS-phase timeout.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   cmd_valid/ready    - command handshake (cmd_ready is combinational)
//   cmd_write/addr/wdata/strb/prot - command payload, sampled on accept
//   rsp_valid/ready    - response handshake
//   rsp_rdata/err/timeout - response payload (rdata is 0 for writes/timeouts)
//   busy               - a transfer is in SETUP or ACCESS
//   psel..pprot        - APB4 request outputs (all registered)
//   prdata/pready/pslverr - APB4 completion inputs
module apb4_master_bridge #(
    parameter int unsigned ADDR_WIDTH     = 3,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLES != 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Count value seen on the last permitted stalled ACCESS cycle.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        (TIMEOUT_CYCLES != 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state, state_d;
    logic [CNT_WIDTH-1:0]    wait_cnt, cnt_d;

    logic                    psel_d, penable_d, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_d;
    logic [STRB_WIDTH-1:0]   pstrb_d;
    logic [2:0]              pprot_d;
    logic                    rsp_valid_d, rsp_err_d, rsp_timeout_d, busy_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_d;

    logic                    accept;
    logic                    timeout_hit;

    // Accept only when idle and the response slot is free or draining now.
    assign cmd_ready   = !rst && (state == IDLE) && (!rsp_valid || rsp_ready);
    assign accept      = cmd_valid && cmd_ready;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST);

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state;
        cnt_d         = wait_cnt;
        psel_d        = psel;
        penable_d     = penable;
        pwrite_d      = pwrite;
        paddr_d       = paddr;
        pwdata_d      = pwdata;
        pstrb_d       = pstrb;
        pprot_d       = pprot;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;

        // Consumed response drops; a newly loaded response below overrides.
        if (rsp_valid && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    pstrb_d   = cmd_write ? cmd_strb : '0;
                    pprot_d   = cmd_prot;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                // pready wins over a timeout on the same cycle.
                if (pready) begin
                    state_d       = IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    pwrite_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d       = IDLE;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    pwrite_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = wait_cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                pwrite_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            pprot       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            wait_cnt    <= cnt_d;
            psel        <= psel_d;
            penable     <= penable_d;
            pwrite      <= pwrite_d;
            paddr       <= paddr_d;
            pwdata      <= pwdata_d;
            pstrb       <= pstrb_d;
            pprot       <= pprot_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_apb4_master_bridge.sv
// tb_apb4_master_bridge: self-checking bench for apb4_master_bridge.
// Inputs are driven and outputs sampled on the falling edge; expected APB
// phases and response contents come from the transfer rules (SETUP for one
// cycle, ACCESS until pready or the timeout limit, response the cycle after).
module tb_apb4_master_bridge;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [2:0]  cmd_addr, cmd_prot;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [2:0]  paddr, pprot;
    logic [31:0] pwdata, prdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    apb4_master_bridge #(
        .ADDR_WIDTH(3), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // Scenario driver: called positioned on the falling edge of the accept
    // cycle; returns positioned on the falling edge of the response cycle.
    task automatic do_txn(input logic wr, input logic [2:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input logic [2:0] pr, input int waits,
                          input logic err, input logic [31:0] rd, input logic hold);
        int          n_acc;
        logic        to;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [3:0]  exp_st;
        logic [42:0] exp_bus;
        to      = (waits >= int'(TIMEOUT));
        n_acc   = to ? int'(TIMEOUT) : waits + 1;
        exp_rd  = (wr || to) ? 32'h0 : rd;
        exp_st  = wr ? st : 4'h0;
        exp_err = to || err;
        exp_bus = {wr, a, wd, exp_st, pr};

        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
        cmd_strb = st; cmd_prot = pr; rsp_ready = 1'b1;
        #1;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL accept: cmd_ready got %b exp 1", cmd_ready);
            miscompares++;
        end
        vectors++;

        for (int k = 1; k <= n_acc + 1; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 3'($urandom);
            cmd_wdata = $urandom; cmd_strb = 4'($urandom); cmd_prot = 3'($urandom);
            if ({psel, penable, busy, rsp_valid, cmd_ready} !== {1'b1, (k >= 2), 1'b1, 1'b0, 1'b0}) begin
                $display("FAIL phase_ctrl cyc %0d: psel/penable/busy/rsp_valid/cmd_ready got %b exp %b",
                         k, {psel, penable, busy, rsp_valid, cmd_ready}, {1'b1, (k >= 2), 3'b100});
                miscompares++;
            end
            vectors++;
            if ({pwrite, paddr, pwdata, pstrb, pprot} !== exp_bus) begin
                $display("FAIL apb_bus cyc %0d: got %h exp %h", k,
                         {pwrite, paddr, pwdata, pstrb, pprot}, exp_bus);
                miscompares++;
            end
            vectors++;
            if (k == 1) begin
                pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
            end else if (!to && (k - 2) == waits) begin
                pready = 1'b1; pslverr = err; prdata = rd;
            end else begin
                pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
            end
        end

        @(negedge clk);
        if ({psel, penable, busy, pwrite, rsp_valid} !== 5'b00001) begin
            $display("FAIL end_ctrl: psel/penable/busy/pwrite/rsp_valid got %b exp 00001",
                     {psel, penable, busy, pwrite, rsp_valid});
            miscompares++;
        end
        vectors++;
        if ({rsp_rdata, rsp_err, rsp_timeout} !== {exp_rd, exp_err, to}) begin
            $display("FAIL response: rdata/err/timeout got %h/%b/%b exp %h/%b/%b",
                     rsp_rdata, rsp_err, rsp_timeout, exp_rd, exp_err, to);
            miscompares++;
        end
        vectors++;
        if ({paddr, pwdata, pstrb, pprot} !== exp_bus[41:0]) begin
            $display("FAIL idle_hold: got %h exp %h", {paddr, pwdata, pstrb, pprot}, exp_bus[41:0]);
            miscompares++;
        end
        vectors++;
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
        rsp_ready = !hold;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        if (cmd_ready !== 1'b0) begin
            $display("FAIL reset_ready: cmd_ready got %b exp 0", cmd_ready);
            miscompares++;
        end
        vectors++;
        if ({psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid,
             rsp_rdata, rsp_err, rsp_timeout, busy} !== 81'h0) begin
            $display("FAIL reset_outputs: got %h exp 0", {psel, penable, pwrite, paddr, pwdata,
                     pstrb, pprot, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy});
            miscompares++;
        end
        vectors++;
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0;
        #1;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL reset_release: cmd_ready got %b exp 1", cmd_ready);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_zero_wait_write();
        @(negedge clk);
        do_txn(1'b1, 3'h0, 32'hDEADBEEF, 4'hF, 3'h0, 0, 1'b0, $urandom, 1'b0);
        @(negedge clk);
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            $display("FAIL rsp_clear: rsp_valid/cmd_ready got %b exp 01", {rsp_valid, cmd_ready});
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_wait_read();
        @(negedge clk);
        do_txn(1'b0, 3'h4, $urandom, 4'hA, 3'h5, 2, 1'b0, 32'hCAFEBABE, 1'b0);
    endtask

    task automatic test_slverr();
        @(negedge clk);
        do_txn(1'b1, 3'h1, $urandom, 4'h3, 3'h2, 1, 1'b1, $urandom, 1'b0);
        do_txn(1'b0, 3'h2, $urandom, 4'hF, 3'h1, 0, 1'b0, 32'h0BAD_F00D, 1'b0);
    endtask

    task automatic test_timeout();
        @(negedge clk);
        do_txn(1'b0, 3'h7, $urandom, 4'h1, 3'h3, int'(TIMEOUT), 1'b0, $urandom, 1'b0);
        @(negedge clk);
        do_txn(1'b0, 3'h3, $urandom, 4'h1, 3'h4, int'(TIMEOUT) - 1, 1'b0, 32'h5A5A_A5A5, 1'b0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        do_txn(1'b0, 3'h5, $urandom, 4'h0, 3'h0, 0, 1'b0, 32'h1234_5678, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'h2; rsp_ready = 1'b0;
            #1;
            if ({cmd_ready, psel, rsp_valid} !== 3'b001) begin
                $display("FAIL backpressure %0d: cmd_ready/psel/rsp_valid got %b exp 001",
                         i, {cmd_ready, psel, rsp_valid});
                miscompares++;
            end
            vectors++;
            if ({rsp_rdata, rsp_err, rsp_timeout} !== {32'h1234_5678, 2'b00}) begin
                $display("FAIL rsp_stable %0d: got %h/%b/%b exp 12345678/0/0",
                         i, rsp_rdata, rsp_err, rsp_timeout);
                miscompares++;
            end
            vectors++;
        end
        @(negedge clk);
        do_txn(1'b1, 3'h2, 32'hA5A5_0F0F, 4'h6, 3'h7, 0, 1'b0, $urandom, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'h6; rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; pready = 1'b0;
        repeat (2) @(negedge clk);
        if ({psel, penable} !== 2'b11) begin
            $display("FAIL mid_access: psel/penable got %b exp 11", {psel, penable});
            miscompares++;
        end
        vectors++;
        rst = 1'b1;
        #1;
        if (cmd_ready !== 1'b0) begin
            $display("FAIL mid_rst_ready: cmd_ready got %b exp 0", cmd_ready);
            miscompares++;
        end
        vectors++;
        @(negedge clk);
        rst = 1'b0; pready = 1'b1; pslverr = 1'b1; prdata = $urandom;
        #1;
        if ({psel, penable, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
            $display("FAIL mid_rst_after: psel/penable/rsp_valid/busy/cmd_ready got %b exp 00001",
                     {psel, penable, rsp_valid, busy, cmd_ready});
            miscompares++;
        end
        vectors++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if ({psel, rsp_valid} !== 2'b00) begin
                $display("FAIL mid_rst_quiet %0d: psel/rsp_valid got %b exp 00", i, {psel, rsp_valid});
                miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_random();
        @(negedge clk);
        for (int n = 0; n < 24; n++) begin
            int waits;
            int gap;
            gap   = $urandom_range(0, 2);
            waits = ($urandom_range(0, 7) == 0) ? int'(TIMEOUT) + $urandom_range(0, 1)
                                                : $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                cmd_valid = 1'b0; pready = 1'($urandom);
            end
            do_txn(1'($urandom), 3'($urandom), $urandom, 4'($urandom), 3'($urandom),
                   waits, 1'($urandom), $urandom, 1'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
